// File: rtl/rle_frame_sequencer.sv
// rle_frame_sequencer
// Frame-level front end for rle_decode. Accepts packed RLE tokens, forwards
// one run per token through a one-entry output register, clamps the final run
// so exactly the latched frame size is issued, and counts decoded pixels to
// detect frame completion.
//
// Handshake contract (token_* and rle_*): a transfer happens on any cycle where
// valid && ready. valid never depends on ready, and the payload stays stable
// while valid && !ready.
module rle_frame_sequencer #(
    parameter int data_width_p  = 2,
    parameter int bus_width_p   = 8,
    parameter int count_width_p = bus_width_p - data_width_p,
    parameter int frame_width_p = 17
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [frame_width_p-1:0] frame_pixels_i,
    input  logic [bus_width_p-1:0]   token_i,
    input  logic                     token_valid_i,
    output logic                     token_ready_o,
    output logic [data_width_p-1:0]  rle_value_o,
    output logic [count_width_p-1:0] rle_count_o,
    output logic                     rle_valid_o,
    input  logic                     rle_ready_i,
    input  logic                     pix_fire_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [frame_width_p-1:0] pix_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [frame_width_p-1:0] remaining_q, remaining_d;
    logic [frame_width_p-1:0] frame_size_q, frame_size_d;
    logic [frame_width_p-1:0] pix_count_q, pix_count_d;
    logic                     error_q, error_d;
    logic                     rle_valid_q, rle_valid_d;
    logic [data_width_p-1:0]  rle_value_q, rle_value_d;
    logic [count_width_p-1:0] rle_count_q, rle_count_d;

    logic [count_width_p-1:0] tok_count;
    logic [data_width_p-1:0]  tok_value;
    logic [frame_width_p-1:0] tok_count_ext;
    logic [frame_width_p-1:0] issued;
    logic                     overrun;
    logic                     token_ready;
    logic                     tok_fire;
    logic                     tok_load;
    logic                     rle_fire;
    logic                     start_accept;
    logic                     pix_active;

    // Token layout: value in the MSBs, run length in the LSBs.
    assign tok_count     = token_i[count_width_p-1:0];
    assign tok_value     = token_i[bus_width_p-1 -: data_width_p];
    assign tok_count_ext = {{(frame_width_p-count_width_p){1'b0}}, tok_count};

    // The last run of a frame is clamped to whatever is left to issue.
    assign issued  = (tok_count_ext < remaining_q) ? tok_count_ext : remaining_q;
    assign overrun = (tok_count_ext > remaining_q);

    // Accept a token only while pixels remain and the output slot is free or draining now.
    assign token_ready  = (state_q == ST_RUN) && (remaining_q != '0) &&
                          (!rle_valid_q || rle_ready_i);
    assign tok_fire     = token_valid_i && token_ready;
    // A zero-length token is consumed but produces nothing; abort discards any token taken this cycle.
    assign tok_load     = tok_fire && (tok_count != '0) && !abort_i;
    assign rle_fire     = rle_valid_q && rle_ready_i;
    assign start_accept = (state_q == ST_IDLE) && start_i && !abort_i;
    assign pix_active   = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !abort_i;

    // Next-state logic for the frame FSM; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (frame_pixels_i != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (remaining_q == '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!rle_valid_q && (pix_count_q == frame_size_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_i) begin
            state_d = ST_IDLE;
        end
    end

    // Datapath next values: frame latch, remaining budget, output register, pixel counter, error flag.
    always_comb begin
        remaining_d  = remaining_q;
        frame_size_d = frame_size_q;
        pix_count_d  = pix_count_q;
        error_d      = error_q;
        rle_valid_d  = rle_valid_q;
        rle_value_d  = rle_value_q;
        rle_count_d  = rle_count_q;

        if (start_accept) begin
            remaining_d  = frame_pixels_i;
            frame_size_d = frame_pixels_i;
            pix_count_d  = '0;
            error_d      = 1'b0;
        end

        if (rle_fire) begin
            rle_valid_d = 1'b0;
        end

        // Loading wins over the accept above so back-to-back runs have no bubble.
        if (tok_load) begin
            remaining_d = remaining_q - issued;
            rle_valid_d = 1'b1;
            rle_value_d = tok_value;
            rle_count_d = issued[count_width_p-1:0];
            if (overrun) begin
                error_d = 1'b1;
            end
        end

        // Pixel counter saturates at the frame size; an extra pixel is an error.
        if (pix_active && pix_fire_i) begin
            if (pix_count_q == frame_size_q) begin
                error_d = 1'b1;
            end else begin
                pix_count_d = pix_count_q + frame_width_p'(1);
            end
        end

        if (abort_i) begin
            rle_valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            frame_size_q <= '0;
            pix_count_q  <= '0;
            error_q      <= 1'b0;
            rle_valid_q  <= 1'b0;
            rle_value_q  <= '0;
            rle_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            frame_size_q <= frame_size_d;
            pix_count_q  <= pix_count_d;
            error_q      <= error_d;
            rle_valid_q  <= rle_valid_d;
            rle_value_q  <= rle_value_d;
            rle_count_q  <= rle_count_d;
        end
    end

    assign token_ready_o = token_ready;
    assign rle_value_o   = rle_value_q;
    assign rle_count_o   = rle_count_q;
    assign rle_valid_o   = rle_valid_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign error_o       = error_q;
    assign pix_count_o   = pix_count_q;

endmodule
